// File: rtl/olink_reset_seq.sv
// Purpose: ordered reset sequencer for QPLL, link MMCM and GTX, with lock timeouts and bounded retries.
// Latency: outputs are registered alongside the state register; link_valid reaches the FSM 2 cycles late.
// Backpressure: none; inputs are level conditions. Option macro OLINK_RESEQ_AUTORECOVER_EN makes link loss in READY retry instead of failing.
module olink_reset_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 125000,
  parameter int VALID_HOLD   = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic       sysClk125,
  input  logic       sysClk125Rst,
  input  logic       restart,
  input  logic       qpll_lock,
  input  logic       qpll_refclklost,
  input  logic       olink_clk_locked,
  input  logic       link_valid,
  output logic       qpll_reset,
  output logic       mmcm_reset,
  output logic       gt_reset,
  output logic       link_ready,
  output logic       seq_fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
);

  localparam logic [2:0] QPLL_RST  = 3'd0;
  localparam logic [2:0] QPLL_WAIT = 3'd1;
  localparam logic [2:0] MMCM_RST  = 3'd2;
  localparam logic [2:0] MMCM_WAIT = 3'd3;
  localparam logic [2:0] GT_RST    = 3'd4;
  localparam logic [2:0] LINK_WAIT = 3'd5;
  localparam logic [2:0] READY     = 3'd6;
  localparam logic [2:0] FAIL      = 3'd7;

  // The cycle counter must cover the lock timeout and never be narrower than 17 bits.
  localparam int CNT_W  = ($clog2(LOCK_TIMEOUT + 1) > 17) ? $clog2(LOCK_TIMEOUT + 1) : 17;
  localparam int HOLD_W = ($clog2(VALID_HOLD + 1) > 1) ? $clog2(VALID_HOLD + 1) : 1;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic [3:0]        r_retry;
  logic              r_vld_meta;
  logic              r_vld_sync;
  logic              r_qpll_reset;
  logic              r_mmcm_reset;
  logic              r_gt_reset;
  logic              r_link_ready;
  logic              r_seq_fail;

  logic [2:0]        w_nxt_state;
  logic [3:0]        w_nxt_retry;
  logic              w_fault;
  logic              w_rst_done;
  logic              w_cnt_tmo;
  logic              w_hold_done;
  logic              w_retry_ok;
  logic              w_lost_range;
  logic              w_link_lost;

  // Counters compare against "one less" because the counter reads 0 on the first cycle of a state.
  assign w_rst_done   = (r_cnt == CNT_W'(RST_CYCLES - 1));
  assign w_cnt_tmo    = (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));
  assign w_hold_done  = r_vld_sync && (r_hold == HOLD_W'(VALID_HOLD - 1));
  assign w_retry_ok   = (r_retry < 4'(MAX_RETRY));
  assign w_lost_range = (r_state >= QPLL_WAIT) && (r_state <= READY);
  assign w_link_lost  = !qpll_lock || !olink_clk_locked || !r_vld_sync;

  // Next-state selection: restart beats refclk loss, which beats normal advance/timeout.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_retry = r_retry;
    w_fault     = 1'b0;
    if (restart) begin
      w_nxt_state = QPLL_RST;
      w_nxt_retry = 4'd0;
    end else if (qpll_refclklost && w_lost_range) begin
      w_fault = 1'b1;
    end else begin
      case (r_state)
        QPLL_RST:  if (w_rst_done) w_nxt_state = QPLL_WAIT;
        QPLL_WAIT: begin
          if (qpll_lock)      w_nxt_state = MMCM_RST;
          else if (w_cnt_tmo) w_fault = 1'b1;
        end
        MMCM_RST:  if (w_rst_done) w_nxt_state = MMCM_WAIT;
        MMCM_WAIT: begin
          if (olink_clk_locked) w_nxt_state = GT_RST;
          else if (w_cnt_tmo)   w_fault = 1'b1;
        end
        GT_RST:    if (w_rst_done) w_nxt_state = LINK_WAIT;
        LINK_WAIT: begin
          if (w_hold_done) begin
            w_nxt_state = READY;
            w_nxt_retry = 4'd0;
          end else if (w_cnt_tmo) begin
            w_fault = 1'b1;
          end
        end
        READY: begin
          if (w_link_lost) begin
`ifdef OLINK_RESEQ_AUTORECOVER_EN
            w_fault = 1'b1;
`else
            w_nxt_state = FAIL;
`endif
          end
        end
        default: w_nxt_state = FAIL;
      endcase
    end
    // A fault retries from the top while budget remains, otherwise parks in FAIL.
    if (w_fault) begin
      if (w_retry_ok) begin
        w_nxt_retry = r_retry + 4'd1;
        w_nxt_state = QPLL_RST;
      end else begin
        w_nxt_state = FAIL;
      end
    end
  end

  // Two-flop synchronizer bringing link_valid into the sysClk125 domain.
  always_ff @(posedge sysClk125) begin
    if (sysClk125Rst) begin
      r_vld_meta <= 1'b0;
      r_vld_sync <= 1'b0;
    end else begin
      r_vld_meta <= link_valid;
      r_vld_sync <= r_vld_meta;
    end
  end

  // State, counters and outputs; outputs decode the next state so they line up with r_state.
  always_ff @(posedge sysClk125) begin
    if (sysClk125Rst) begin
      r_state      <= QPLL_RST;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_retry      <= 4'd0;
      r_qpll_reset <= 1'b1;
      r_mmcm_reset <= 1'b1;
      r_gt_reset   <= 1'b1;
      r_link_ready <= 1'b0;
      r_seq_fail   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_retry <= w_nxt_retry;
      if (restart || (w_nxt_state != r_state)) r_cnt <= '0;
      else                                     r_cnt <= r_cnt + CNT_W'(1);
      if ((r_state == LINK_WAIT) && (w_nxt_state == LINK_WAIT) && !restart && r_vld_sync)
        r_hold <= r_hold + HOLD_W'(1);
      else
        r_hold <= '0;
      r_qpll_reset <= (w_nxt_state == QPLL_RST) || (w_nxt_state == FAIL);
      r_mmcm_reset <= (w_nxt_state <= MMCM_RST) || (w_nxt_state == FAIL);
      r_gt_reset   <= (w_nxt_state <= GT_RST)   || (w_nxt_state == FAIL);
      r_link_ready <= (w_nxt_state == READY);
      r_seq_fail   <= (w_nxt_state == FAIL);
    end
  end

  assign qpll_reset = r_qpll_reset;
  assign mmcm_reset = r_mmcm_reset;
  assign gt_reset   = r_gt_reset;
  assign link_ready = r_link_ready;
  assign seq_fail   = r_seq_fail;
  assign state      = r_state;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_olink_reset_seq.sv
// Bench for olink_reset_seq: vector table, hand-written corner sequences, then randomized traffic
// compared every cycle against a phase/dwell reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_olink_reset_seq;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int VALID_HOLD   = 8;
  localparam int MAX_RETRY    = 2;

  localparam int P_QRST = 0, P_QWAIT = 1, P_MRST = 2, P_MWAIT = 3;
  localparam int P_GRST = 4, P_LWAIT = 5, P_READY = 6, P_FAIL = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rs = 1'b0, ql = 1'b1, lost = 1'b0, mk = 1'b1, lv = 1'b1;
  logic       qpll_reset, mmcm_reset, gt_reset, link_ready, seq_fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  int n_chk = 0;
  int n_err = 0;

  olink_reset_seq #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .VALID_HOLD(VALID_HOLD), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .sysClk125(clk), .sysClk125Rst(rst), .restart(rs),
    .qpll_lock(ql), .qpll_refclklost(lost), .olink_clk_locked(mk), .link_valid(lv),
    .qpll_reset(qpll_reset), .mmcm_reset(mmcm_reset), .gt_reset(gt_reset),
    .link_ready(link_ready), .seq_fail(seq_fail), .state(state), .retry_cnt(retry_cnt)
  );

  always #4 clk = ~clk;

  // Reference model: phase number, cycles spent in phase, consecutive synced-valid run, retries.
  int m_ph = P_QRST, m_dwell = 0, m_run = 0, m_retry = 0;
  bit vq[$] = '{1'b0, 1'b0};

  function automatic void m_go(int ph);
    m_ph = ph; m_dwell = 0; m_run = 0;
  endfunction

  function automatic void m_fault();
    if (m_retry < MAX_RETRY) begin m_retry++; m_go(P_QRST); end
    else m_go(P_FAIL);
  endfunction

  function automatic void model_step(bit r, bit rq, bit l, bit lo, bit m, bit v_in);
    bit v;
    if (r) begin m_retry = 0; m_go(P_QRST); vq = '{1'b0, 1'b0}; return; end
    v = vq.pop_front();
    vq.push_back(v_in);
    m_dwell++;
    if (rq) begin m_retry = 0; m_go(P_QRST); end
    else if (lo && m_ph != P_QRST && m_ph != P_FAIL) m_fault();
    else begin
      case (m_ph)
        P_QRST:  if (m_dwell == RST_CYCLES) m_go(P_QWAIT);
        P_QWAIT: if (l) m_go(P_MRST); else if (m_dwell == LOCK_TIMEOUT) m_fault();
        P_MRST:  if (m_dwell == RST_CYCLES) m_go(P_MWAIT);
        P_MWAIT: if (m) m_go(P_GRST); else if (m_dwell == LOCK_TIMEOUT) m_fault();
        P_GRST:  if (m_dwell == RST_CYCLES) m_go(P_LWAIT);
        P_LWAIT: begin
          m_run = v ? m_run + 1 : 0;
          if (m_run == VALID_HOLD) begin m_retry = 0; m_go(P_READY); end
          else if (m_dwell == LOCK_TIMEOUT) m_fault();
        end
        P_READY: if (!l || !m || !v) begin
`ifdef OLINK_RESEQ_AUTORECOVER_EN
          m_fault();
`else
          m_go(P_FAIL);
`endif
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [11:0] model_obs();
    logic qr, mr, gr;
    qr = (m_ph == P_QRST) || (m_ph == P_FAIL);
    mr = (m_ph <= P_MRST) || (m_ph == P_FAIL);
    gr = (m_ph <= P_GRST) || (m_ph == P_FAIL);
    return {3'(m_ph), 4'(m_retry), qr, mr, gr, m_ph == P_READY, m_ph == P_FAIL};
  endfunction

  function automatic logic [11:0] dut_obs();
    return {state, retry_cnt, qpll_reset, mmcm_reset, gt_reset, link_ready, seq_fail};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got st=%0d rc=%0d flags(qr,mr,gr,lr,sf)=%b want st=%0d rc=%0d flags=%b @%0t",
               name, act[11:9], act[8:5], act[4:0], exp[11:9], exp[8:5], exp[4:0], $time);
    end
  endtask

  // One clock: apply inputs, advance DUT and model, then compare the two.
  task automatic step(input logic r, input logic rq, input logic l, input logic lo,
                      input logic m, input logic v);
    rst = r; rs = rq; ql = l; lost = lo; mk = m; lv = v;
    @(posedge clk);
    model_step(r, rq, l, lo, m, v);
    #1;
    chk("model", dut_obs(), model_obs());
  endtask

  task automatic steps(input int n, input logic l, input logic m, input logic v);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, l, 1'b0, m, v);
  endtask

  typedef struct {
    logic       r, rq, l, lo, m, v;
    int         n;
    logic [2:0] st;
    logic [3:0] rc;
    logic [4:0] fl;   // qpll_reset, mmcm_reset, gt_reset, link_ready, seq_fail
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Clean bring-up with every condition good, then a lock loss in READY and a restart.
    tbl[0]  = '{1, 0, 1, 0, 1, 1, 1, 3'd0, 4'd0, 5'b11100};
    tbl[1]  = '{0, 0, 1, 0, 1, 1, 3, 3'd0, 4'd0, 5'b11100};
    tbl[2]  = '{0, 0, 1, 0, 1, 1, 1, 3'd1, 4'd0, 5'b01100};
    tbl[3]  = '{0, 0, 1, 0, 1, 1, 1, 3'd2, 4'd0, 5'b01100};
    tbl[4]  = '{0, 0, 1, 0, 1, 1, 4, 3'd3, 4'd0, 5'b00100};
    tbl[5]  = '{0, 0, 1, 0, 1, 1, 1, 3'd4, 4'd0, 5'b00100};
    tbl[6]  = '{0, 0, 1, 0, 1, 1, 4, 3'd5, 4'd0, 5'b00000};
    tbl[7]  = '{0, 0, 1, 0, 1, 1, 7, 3'd5, 4'd0, 5'b00000};
    tbl[8]  = '{0, 0, 1, 0, 1, 1, 1, 3'd6, 4'd0, 5'b00010};
`ifdef OLINK_RESEQ_AUTORECOVER_EN
    tbl[9]  = '{0, 0, 1, 0, 0, 1, 1, 3'd0, 4'd1, 5'b11100};
`else
    tbl[9]  = '{0, 0, 1, 0, 0, 1, 1, 3'd7, 4'd0, 5'b11101};
`endif
    tbl[10] = '{0, 1, 1, 0, 1, 1, 1, 3'd0, 4'd0, 5'b11100};
    tbl[11] = '{0, 0, 1, 0, 1, 1, 4, 3'd1, 4'd0, 5'b01100};

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].r, tbl[i].rq, tbl[i].l, tbl[i].lo, tbl[i].m, tbl[i].v);
      chk($sformatf("vec%0d", i), dut_obs(), {tbl[i].st, tbl[i].rc, tbl[i].fl});
    end

    // QPLL never locks: two retries, then FAIL on the third timeout.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    steps(4, 1'b0, 1'b1, 1'b1);
    chk("nolock_wait", dut_obs(), {3'd1, 4'd0, 5'b01100});
    steps(20, 1'b0, 1'b1, 1'b1);
    chk("nolock_retry1", dut_obs(), {3'd0, 4'd1, 5'b11100});
    steps(24, 1'b0, 1'b1, 1'b1);
    chk("nolock_retry2", dut_obs(), {3'd0, 4'd2, 5'b11100});
    steps(24, 1'b0, 1'b1, 1'b1);
    chk("nolock_fail", dut_obs(), {3'd7, 4'd2, 5'b11101});
    steps(10, 1'b1, 1'b1, 1'b1);
    chk("fail_sticky", dut_obs(), {3'd7, 4'd2, 5'b11101});

    // Valid glitch in LINK_WAIT restarts the hold count.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    steps(14, 1'b1, 1'b1, 1'b0);
    chk("glitch_lwait", dut_obs(), {3'd5, 4'd0, 5'b00000});
    steps(5, 1'b1, 1'b1, 1'b1);
    steps(1, 1'b1, 1'b1, 1'b0);
    steps(9, 1'b1, 1'b1, 1'b1);
    chk("glitch_not_yet", dut_obs(), {3'd5, 4'd0, 5'b00000});
    steps(1, 1'b1, 1'b1, 1'b1);
    chk("glitch_ready", dut_obs(), {3'd6, 4'd0, 5'b00010});

    // Restart coincides with a LINK_WAIT timeout.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    steps(14 + LOCK_TIMEOUT - 1, 1'b1, 1'b1, 1'b0);
    chk("tmo_edge_lwait", dut_obs(), {3'd5, 4'd0, 5'b00000});
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("restart_prio", dut_obs(), {3'd0, 4'd0, 5'b11100});

    // refclk loss while waiting for the MMCM counts as a retry.
    steps(5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("refclklost", dut_obs(), {3'd0, 4'd1, 5'b11100});

    // Mid-sequence reset in MMCM_WAIT after one MMCM timeout.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    steps(38, 1'b1, 1'b0, 1'b1);
    chk("mwait_retry1", dut_obs(), {3'd3, 4'd1, 5'b00100});
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("midseq_reset", dut_obs(), {3'd0, 4'd0, 5'b11100});
    steps(4, 1'b1, 1'b0, 1'b1);
    chk("post_reset_seq", dut_obs(), {3'd1, 4'd0, 5'b01100});

    // Randomized traffic with slowly changing reliability profiles.
    begin
      int pct;
      pct = 99;
      for (int i = 0; i < 6000; i++) begin
        if (i % 250 == 0) begin
          case ($urandom_range(0, 2))
            0:       pct = 99;
            1:       pct = 93;
            default: pct = 70;
          endcase
        end
        step($urandom_range(0, 599) == 0, $urandom_range(0, 399) == 0,
             $urandom_range(0, 99) < pct, $urandom_range(0, 299) == 0,
             $urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
